// File: rtl/low_power_pkg.sv
// low_power_pkg: shared state encoding and default delays for the Q-channel power controller
package low_power_pkg;
  typedef enum logic [2:0] {
    RUN    = 3'd0,
    Q_REQ  = 3'd1,
    ISO_ON = 3'd2,
    SLEEP  = 3'd3,
    PWR_UP = 3'd4,
    CLK_ON = 3'd5,
    Q_EXIT = 3'd6
  } qpc_state_t;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int DEF_ISO_DELAY   = 2;
  localparam int DEF_PWR_DELAY   = 4;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/qpc_delay_counter.sv
// qpc_delay_counter: up-counter that pulses done on its last count and clears whenever disabled
module qpc_delay_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         done
);
  logic [W-1:0] count;
  assign done = en && count == last;
  // restart from zero when disabled or on completion, so every state entry sees a clean count
  always_ff @(posedge clk)
    count <= (reset || !en || done) ? '0 : count + 1'b1;
endmodule

// File: rtl/qchannel_power_ctrl.sv
// qchannel_power_ctrl: idle-triggered Q-channel quiesce, isolate, clock-gate and power-off sequencer
module qchannel_power_ctrl
  import low_power_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int ISO_DELAY   = DEF_ISO_DELAY,
  parameter int PWR_DELAY   = DEF_PWR_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qactive_i,
  input  logic       qacceptn_i,
  input  logic       wake_i,
  input  logic       pd_enable_i,
  output logic       qreqn_o,
  output logic       clk_en_o,
  output logic       iso_en_o,
  output logic       pwr_on_o,
  output logic [2:0] state_o
);
  localparam int W = $clog2(max3(IDLE_CYCLES, ISO_DELAY, PWR_DELAY) + 1);
  qpc_state_t state;
  logic wake, idle, cnt_en, done;
  logic [W-1:0] last;
  assign wake = qactive_i | wake_i;
  assign idle = !qactive_i && pd_enable_i && !wake_i;
  // one shared timer: idle run in RUN, isolation hold in ISO_ON, power ramp in PWR_UP
  always_comb begin
    cnt_en = state == RUN ? idle : state == ISO_ON ? !wake : state == PWR_UP;
    last   = state == RUN ? W'(IDLE_CYCLES - 1) : state == ISO_ON ? W'(ISO_DELAY - 1) : W'(PWR_DELAY - 1);
  end
  qpc_delay_counter #(.W(W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .last  (last),
    .done  (done)
  );
  // power sequencing state machine; a wake coinciding with idle expiry keeps RUN because idle excludes wake
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else
      case (state)
        RUN:     if (idle && done) state <= Q_REQ;
        Q_REQ:   if (!qacceptn_i) state <= ISO_ON;
        ISO_ON:  state <= wake ? Q_EXIT : done ? SLEEP : ISO_ON;
        SLEEP:   if (wake) state <= PWR_UP;
        PWR_UP:  if (done) state <= CLK_ON;
        CLK_ON:  state <= Q_EXIT;
        Q_EXIT:  if (qacceptn_i) state <= RUN;
        default: state <= RUN;
      endcase
  end
  assign qreqn_o  = state == RUN || state == Q_EXIT;
  assign clk_en_o = !(state == SLEEP || state == PWR_UP);
  assign iso_en_o = state == ISO_ON || state == SLEEP || state == PWR_UP || state == CLK_ON;
  assign pwr_on_o = state != SLEEP;
  assign state_o  = state;
endmodule

// File: tb/tb_qchannel_power_ctrl.sv
// tb_qchannel_power_ctrl: vector table, corner sequences and random run against a behavioural model
module tb_qchannel_power_ctrl;
  localparam int IDLE = 8;
  localparam int ISO  = 2;
  localparam int PWR  = 4;
  localparam logic [6:0] RUNV = 7'b000_1101;
  localparam logic [6:0] QRQV = 7'b001_0101;
  localparam logic [6:0] ISOV = 7'b010_0111;
  localparam logic [6:0] SLPV = 7'b011_0010;
  localparam logic [6:0] PWRV = 7'b100_0011;
  localparam logic [6:0] CLKV = 7'b101_0111;
  localparam logic [6:0] QEXV = 7'b110_1101;
  typedef struct {
    logic r, qa, qacc, wk, pd;
    logic [6:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset, qactive_i, qacceptn_i, wake_i, pd_enable_i;
  logic qreqn_o, clk_en_o, iso_en_o, pwr_on_o;
  logic [2:0] state_o;
  int total = 0, bad = 0;
  int m_st = 0, m_idle = 0, m_rem = 0;
  vec_t tbl[26];
  always #5 clk = ~clk;
  qchannel_power_ctrl #(.IDLE_CYCLES(IDLE), .ISO_DELAY(ISO), .PWR_DELAY(PWR)) dut (
    .clk         (clk),
    .reset       (reset),
    .qactive_i   (qactive_i),
    .qacceptn_i  (qacceptn_i),
    .wake_i      (wake_i),
    .pd_enable_i (pd_enable_i),
    .qreqn_o     (qreqn_o),
    .clk_en_o    (clk_en_o),
    .iso_en_o    (iso_en_o),
    .pwr_on_o    (pwr_on_o),
    .state_o     (state_o)
  );
  function automatic logic [6:0] got();
    return {state_o, qreqn_o, clk_en_o, iso_en_o, pwr_on_o};
  endfunction
  function automatic logic [6:0] model_out();
    int s = m_st;
    return {3'(s), s == 0 || s == 6, !(s == 3 || s == 4), s >= 2 && s <= 5, s != 3};
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  task automatic drive(input logic r, input logic qa, input logic qacc, input logic wk, input logic pd);
    reset = r; qactive_i = qa; qacceptn_i = qacc; wake_i = wk; pd_enable_i = pd;
  endtask
  task automatic model_step();
    if (reset) begin
      m_st = 0; m_idle = 0;
    end else
      case (m_st)
        0: if (!qactive_i && pd_enable_i && !wake_i) begin
             m_idle++;
             if (m_idle == IDLE) begin m_st = 1; m_idle = 0; end
           end else m_idle = 0;
        1: if (!qacceptn_i) begin m_st = 2; m_rem = ISO; end
        2: if (qactive_i || wake_i) m_st = 6;
           else begin m_rem--; if (m_rem == 0) m_st = 3; end
        3: if (qactive_i || wake_i) begin m_st = 4; m_rem = PWR; end
        4: begin m_rem--; if (m_rem == 0) m_st = 5; end
        5: m_st = 6;
        default: if (qacceptn_i) begin m_st = 0; m_idle = 0; end
      endcase
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'(got()), 32'(model_out()));
  endtask
  task automatic go_sleep();
    drive(1, 0, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 1); repeat (IDLE) tick();
    drive(0, 0, 0, 0, 1); repeat (ISO + 1) tick();
    chk("reach_sleep", 32'(got()), 32'(SLPV));
  endtask
  initial begin
    int n;
    logic flag;
    drive(1, 0, 1, 0, 1);
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, RUNV};
    for (int i = 1; i < 8; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, RUNV};
    for (int i = 8; i < 14; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, QRQV};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, QRQV};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ISOV};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ISOV};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SLPV};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SLPV};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PWRV};
    for (int i = 19; i < 22; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PWRV};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PWRV};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CLKV};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, QEXV};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, QEXV};
    tbl[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RUNV};
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].r, tbl[i].qa, tbl[i].qacc, tbl[i].wk, tbl[i].pd);
      tick();
      chk($sformatf("vec%0d", i), 32'(got()), 32'(tbl[i].exp));
    end
    drive(1, 0, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 1); repeat (IDLE - 1) tick();
    drive(0, 1, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 1);
    n = 0;
    while (qreqn_o && n < 20) begin tick(); n++; end
    chk("idle_restart_latency", 32'(n), 32'(IDLE));
    drive(1, 0, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 1); repeat (IDLE - 1) tick();
    drive(0, 0, 1, 1, 1); tick();
    chk("wake_at_expiry", 32'(got()), 32'(RUNV));
    drive(0, 0, 1, 0, 1); tick();
    chk("wake_clears_idle", 32'(got()), 32'(RUNV));
    drive(1, 0, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 0);
    flag = 1'b0;
    repeat (30) begin tick(); if (!qreqn_o) flag = 1'b1; end
    chk("pd_disable_blocks", 32'(flag), 32'd0);
    drive(1, 0, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 1); repeat (IDLE) tick();
    drive(0, 0, 0, 0, 1); tick();
    chk("abort_iso_entry", 32'(got()), 32'(ISOV));
    flag = 1'b0;
    drive(0, 1, 0, 0, 1); tick();
    chk("abort_to_qexit", 32'(got()), 32'(QEXV));
    if (!clk_en_o || !pwr_on_o) flag = 1'b1;
    drive(0, 1, 1, 0, 1); tick();
    if (!clk_en_o || !pwr_on_o) flag = 1'b1;
    chk("abort_back_run", 32'(got()), 32'(RUNV));
    chk("abort_never_off", 32'(flag), 32'd0);
    go_sleep();
    drive(1, 0, 0, 0, 1); tick();
    chk("reset_in_sleep", 32'(got()), 32'(RUNV));
    go_sleep();
    drive(0, 0, 0, 1, 1); tick();
    chk("enter_pwr_up", 32'(got()), 32'(PWRV));
    drive(1, 0, 0, 0, 1); tick();
    chk("reset_in_pwr_up", 32'(got()), 32'(RUNV));
    repeat (3000)
      begin
        drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0);
        tick();
      end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
